mac_learn_table: RTL and testbench
==================================

Name: mac_learn_table

Overview:
- Stateful MAC address learning and forwarding table, directly downstream of the header parser. Consumes the replacement-policy definitions in address_table_pkg: NUM_ENTRIES and MAX_HIT.
- Per frame: learns the source MAC against its ingress port, looks up the destination MAC, and returns an egress port mask to the switch fabric arbiter.
- Hit counters drive eviction when full and ageing on a periodic tick.

Parameters:
- NUM_PORTS, 4 (from switch_pkg): number of switch ports.
- NUM_ENTRIES, NUM_PORTS*4: table depth.
- MAX_HIT, 16: hit counter range; counter width is $clog2(MAX_HIT), saturating at MAX_HIT-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  frame header request valid.
- req_ready  out  1  table accepts request.
- req_src_mac  in  48  source MAC.
- req_dst_mac  in  48  destination MAC.
- req_src_port  in  $clog2(NUM_PORTS)  ingress port.
- resp_valid  out  1  forwarding decision valid.
- resp_ready  in  1  consumer accepts decision.
- resp_port_mask  out  NUM_PORTS  egress port mask.
- resp_hit  out  1  destination found in table.
- age_tick  in  1  single-cycle ageing pulse.
- evict_pulse  out  1  one-cycle pulse when a valid entry is overwritten.
- table_full  out  1  all entries valid.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All entry valid bits, MACs, ports and hit counters clear.
  - State = IDLE, age_pending = 0.
  - req_ready=0, resp_valid=0, resp_port_mask=0, resp_hit=0, evict_pulse=0, table_full=0.
  - Reset mid-operation aborts the request; no response is issued.
- FSM states: IDLE, AGE, LEARN, LOOKUP, RESP.
  - IDLE: req_ready=1 only if age_pending=0.
    - If age_pending=1, go to AGE.
    - Else on req_valid, capture the request and go to LEARN.
  - AGE (1 cycle), for every valid entry:
    - hit==0: clear valid.
    - Otherwise: decrement hit by 1.
    - Then clear age_pending and return to IDLE.
  - LEARN (1 cycle):
    - If src MAC bit 40 (group bit) is set, skip learning.
    - Else, if a valid entry matches src MAC: update its port and saturating-increment its hit.
    - Else allocate: use the lowest-index invalid entry. If none is invalid, use the entry with the minimum hit, ties going to the highest index.
    - On allocation, write MAC and port and set hit=0. Pulse evict_pulse if the target entry was valid.
  - LOOKUP (1 cycle):
    - dst == FF:FF:FF:FF:FF:FF or dst group bit set: mask = all ones except src port, resp_hit=0.
    - Else valid match: saturating-increment hit, resp_hit=1, mask = one-hot(entry port). If the entry port equals src port, mask=0 (filtered).
    - Else miss: flood mask (all except src port), resp_hit=0.
  - RESP: resp_valid=1. Outputs are held stable until resp_ready. On the handshake, return to IDLE; resp_valid drops the next cycle.
- Latency: request accepted in cycle N gives resp_valid at N+3 (no ageing pending).
- Ordering and simultaneity:
  - Learning precedes lookup, so src==dst in the same frame sees the just-learned entry and is filtered.
  - An age_tick in any state sets age_pending. A second tick while pending is absorbed (one decrement).
  - The AGE operation has priority over a new request in IDLE.
- Hit counters: width $clog2(MAX_HIT); increments never wrap, saturating at MAX_HIT-1 (15 by default).
- table_full: registered, equal to the AND of all valid bits, updated the cycle after any valid-bit change.
- The request is registered on acceptance; req_* inputs may change after the handshake.

Test Plan:
- Reset then learn, 4 ports: request src=00:00:00:00:00:01 port 2, dst=00:00:00:00:00:02 → resp_hit=0, mask=4'b1011, at N+3. Then request src=::02 port 0, dst=::01 → resp_hit=1, mask=4'b0100.
- Fill and evict: learn 16 distinct unicast MACs, then look up entry 5 three times. A 17th MAC → evict_pulse=1 and replaces the highest-index entry with hit=0 (entry 15). table_full stays 1.
- Saturation: 20 lookups of one MAC → its hit reads 15, not wrapping to 0 (check via eviction order, white-box or by probing).
- Ageing: learn MAC A (hit=0) and MAC B (hit=2), then pulse age_tick once. A is invalidated (lookup floods, resp_hit=0); B survives with hit=1 (lookup resp_hit=1).
- Tick during busy: age_tick while in LOOKUP → request completes normally. The next cycle in IDLE holds req_ready=0 for one cycle (AGE), then req_ready=1. Two ticks in a row apply only one decrement.
- Broadcast/filter/backpressure: dst=FF:FF:FF:FF:FF:FF from port 1 → mask=4'b1101. src==dst from port 3 → mask=4'b0000. resp_ready held low 5 cycles → outputs stable. Asserting rst_n=0 in RESP clears resp_valid immediately.

Source files
------------

// File: rtl/mac_learn_table_if.sv
// Request/response bundle between the header parser, the MAC table and the fabric arbiter.
// The parser side uses the master modport; the table uses the slave modport.
interface mac_learn_table_if #(
   parameter int NUM_PORTS = 4
) ();
   localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic                 req_valid;
   logic                 req_ready;
   logic [47:0]          req_src_mac;
   logic [47:0]          req_dst_mac;
   logic [PORT_W-1:0]    req_src_port;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [NUM_PORTS-1:0] resp_port_mask;
   logic                 resp_hit;

   modport master (
      output req_valid, req_src_mac, req_dst_mac, req_src_port, resp_ready,
      input  req_ready, resp_valid, resp_port_mask, resp_hit
   );

   modport slave (
      input  req_valid, req_src_mac, req_dst_mac, req_src_port, resp_ready,
      output req_ready, resp_valid, resp_port_mask, resp_hit
   );
endinterface

// File: rtl/mac_learn_table.sv
// MAC learning/forwarding table: learns source MAC per frame, looks up destination, returns an
// egress port mask. Hit counters steer eviction when full and are decremented by periodic ageing.
module mac_learn_table #(
   parameter int NUM_PORTS   = 4,
   parameter int NUM_ENTRIES = NUM_PORTS * 4,
   parameter int MAX_HIT     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   mac_learn_table_if.slave  bus,
   input  logic              age_tick,
   output logic              evict_pulse,
   output logic              table_full
);
   localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int IDX_W  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int HIT_W  = (MAX_HIT > 1) ? $clog2(MAX_HIT) : 1;
   localparam logic [HIT_W-1:0] HIT_TOP = HIT_W'(MAX_HIT - 1);
   localparam logic [47:0]      BCAST   = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [2:0] {IDLE, AGE, LEARN, LOOKUP, RESP} state_t;

   state_t               state;
   state_t               next_state;
   logic                 age_pending;
   logic                 age_pending_d;
   logic                 accept;

   logic [47:0]          cap_src_mac;
   logic [47:0]          cap_dst_mac;
   logic [PORT_W-1:0]    cap_src_port;

   logic [NUM_ENTRIES-1:0] valid;
   logic [47:0]          mac  [NUM_ENTRIES];
   logic [PORT_W-1:0]    port [NUM_ENTRIES];
   logic [HIT_W-1:0]     hit  [NUM_ENTRIES];

   logic                 src_found;
   logic [IDX_W-1:0]     src_idx;
   logic                 dst_found;
   logic [IDX_W-1:0]     dst_idx;
   logic                 free_found;
   logic [IDX_W-1:0]     free_idx;
   logic [IDX_W-1:0]     victim_idx;
   logic [HIT_W-1:0]     min_hit;
   logic [IDX_W-1:0]     alloc_idx;
   logic                 learn_alloc;

   logic                 req_ready_d;
   logic                 resp_valid_d;
   logic [NUM_PORTS-1:0] lookup_mask;
   logic                 lookup_hit;

   function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] h);
      return (h >= HIT_TOP) ? h : h + 1'b1;
   endfunction

   function automatic logic [NUM_PORTS-1:0] one_hot(input logic [PORT_W-1:0] p);
      return {{(NUM_PORTS-1){1'b0}}, 1'b1} << p;
   endfunction

   assign accept = bus.req_valid && bus.req_ready;

   // Request is captured on the handshake so the parser may move on immediately.
   always_ff @(posedge clk) begin
      if (accept) begin
         cap_src_mac  <= bus.req_src_mac;
         cap_dst_mac  <= bus.req_dst_mac;
         cap_src_port <= bus.req_src_port;
      end
   end

   // Associative searches over the table contents.
   always_comb begin
      src_found  = 1'b0;
      src_idx    = '0;
      dst_found  = 1'b0;
      dst_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      victim_idx = '0;
      min_hit    = hit[0];
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (!src_found && valid[i] && mac[i] == cap_src_mac) begin
            src_found = 1'b1;
            src_idx   = IDX_W'(i);
         end
         if (!dst_found && valid[i] && mac[i] == cap_dst_mac) begin
            dst_found = 1'b1;
            dst_idx   = IDX_W'(i);
         end
         if (!free_found && !valid[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         // "<=" lets a later entry with an equal count win the tie.
         if (hit[i] <= min_hit) begin
            min_hit    = hit[i];
            victim_idx = IDX_W'(i);
         end
      end
      alloc_idx   = free_found ? free_idx : victim_idx;
      learn_alloc = !cap_src_mac[40] && !src_found;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         age_pending <= 1'b0;
      end else begin
         state       <= next_state;
         age_pending <= age_pending_d;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (age_pending) next_state = AGE;
                  else if (accept) next_state = LEARN;
         AGE:     next_state = IDLE;
         LEARN:   next_state = LOOKUP;
         LOOKUP:  next_state = RESP;
         RESP:    if (bus.resp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      age_pending_d = age_tick || (age_pending && state != AGE);
      req_ready_d   = (next_state == IDLE) && !age_pending_d;
      resp_valid_d  = (next_state == RESP);
      lookup_hit    = 1'b0;
      lookup_mask   = ~one_hot(cap_src_port);
      if (cap_dst_mac != BCAST && !cap_dst_mac[40] && dst_found) begin
         lookup_hit  = 1'b1;
         lookup_mask = (port[dst_idx] == cap_src_port) ? '0 : one_hot(port[dst_idx]);
      end
   end

   // Outputs are registered so they reset low and stay stable through RESP backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.req_ready      <= 1'b0;
         bus.resp_valid     <= 1'b0;
         bus.resp_port_mask <= '0;
         bus.resp_hit       <= 1'b0;
         evict_pulse        <= 1'b0;
         table_full         <= 1'b0;
      end else begin
         bus.req_ready  <= req_ready_d;
         bus.resp_valid <= resp_valid_d;
         if (state == LOOKUP) begin
            bus.resp_port_mask <= lookup_mask;
            bus.resp_hit       <= lookup_hit;
         end
         evict_pulse <= (state == LEARN) && learn_alloc && valid[alloc_idx];
         table_full  <= &valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid[i] <= 1'b0;
            mac[i]   <= '0;
            port[i]  <= '0;
            hit[i]   <= '0;
         end
      end else begin
         unique case (state)
            AGE: begin
               for (int i = 0; i < NUM_ENTRIES; i++) begin
                  if (valid[i]) begin
                     if (hit[i] == '0) valid[i] <= 1'b0;
                     else              hit[i]   <= hit[i] - 1'b1;
                  end
               end
            end
            LEARN: begin
               // Group source addresses are never learned.
               if (!cap_src_mac[40]) begin
                  if (src_found) begin
                     port[src_idx] <= cap_src_port;
                     hit[src_idx]  <= sat_inc(hit[src_idx]);
                  end else begin
                     valid[alloc_idx] <= 1'b1;
                     mac[alloc_idx]   <= cap_src_mac;
                     port[alloc_idx]  <= cap_src_port;
                     hit[alloc_idx]   <= '0;
                  end
               end
            end
            LOOKUP: begin
               if (cap_dst_mac != BCAST && !cap_dst_mac[40] && dst_found)
                  hit[dst_idx] <= sat_inc(hit[dst_idx]);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_learn_table.sv
// Directed bench for mac_learn_table: learning, lookup, eviction, saturation, ageing,
// backpressure and reset behaviour with hand-computed expected masks.
module tb_mac_learn_table;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] GRP   = 48'h0100_0000_0000;

   logic clk;
   logic rst_n;
   logic age_tick;
   logic evict_pulse;
   logic table_full;
   int   n_tests;
   int   n_fail;

   mac_learn_table_if #(.NUM_PORTS(4)) bus ();

   mac_learn_table #(.NUM_PORTS(4), .NUM_ENTRIES(16), .MAX_HIT(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .age_tick    (age_tick),
      .evict_pulse (evict_pulse),
      .table_full  (table_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [47:0] s, input logic [47:0] d, input logic [1:0] p,
                       input int hold, output logic [3:0] m, output logic h, output logic ev);
      int n;
      int lat;
      ev = 1'b0;
      n  = 0;
      while (bus.req_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      bus.resp_ready   = (hold == 0);
      bus.req_valid    = 1'b1;
      bus.req_src_mac  = s;
      bus.req_dst_mac  = d;
      bus.req_src_port = p;
      @(negedge clk);
      bus.req_valid    = 1'b0;
      bus.req_src_mac  = ~s;
      bus.req_dst_mac  = ~d;
      bus.req_src_port = ~p;
      lat = 1;
      while (bus.resp_valid !== 1'b1 && lat < 20) begin
         ev |= evict_pulse;
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 3);
      m = bus.resp_port_mask;
      h = bus.resp_hit;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("hold_valid", bus.resp_valid, 1);
         check("hold_mask", bus.resp_port_mask, m);
         check("hold_hit", bus.resp_hit, h);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      check("resp_drop", bus.resp_valid, 0);
   endtask

   task automatic tick(input int cycles);
      @(negedge clk);
      age_tick = 1'b1;
      repeat (cycles) @(negedge clk);
      age_tick = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] m;
      logic       h;
      logic       ev;
      int         n;
      n_tests = 0;
      n_fail  = 0;
      rst_n            = 1'b0;
      age_tick         = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_src_mac  = '0;
      bus.req_dst_mac  = '0;
      bus.req_src_port = '0;
      bus.resp_ready   = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_mask", bus.resp_port_mask, 0);
      check("rst_hit", bus.resp_hit, 0);
      check("rst_evict", evict_pulse, 0);
      check("rst_full", table_full, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", bus.req_ready, 1);

      // Basic learn then hit
      send(48'h1, 48'h2, 2'd2, 0, m, h, ev);
      check("learn1_mask", m, 4'b1011);
      check("learn1_hit", h, 0);
      send(48'h2, 48'h1, 2'd0, 0, m, h, ev);
      check("learn2_mask", m, 4'b0100);
      check("learn2_hit", h, 1);

      // Broadcast, filtering, backpressure
      send(48'h3, BCAST, 2'd1, 0, m, h, ev);
      check("bcast_mask", m, 4'b1101);
      check("bcast_hit", h, 0);
      send(48'h4, 48'h4, 2'd3, 0, m, h, ev);
      check("filter_mask", m, 4'b0000);
      check("filter_hit", h, 1);
      send(48'h5, 48'h1, 2'd0, 5, m, h, ev);
      check("bp_mask", m, 4'b0100);
      check("bp_hit", h, 1);

      // Fill, then evict the highest-index zero-hit entry
      do_reset();
      for (int i = 0; i < 16; i++) begin
         send(48'h100 + 48'(i), BCAST, 2'(i % 4), 0, m, h, ev);
         check("fill_mask", m, 4'hF & ~(4'b1 << (i % 4)));
         check("fill_ev", ev, 0);
         if (i == 14) check("full_at_15", table_full, 0);
      end
      check("full_at_16", table_full, 1);
      for (int i = 0; i < 3; i++) begin
         send(GRP, 48'h105, 2'd0, 0, m, h, ev);
         check("e5_mask", m, 4'b0010);
         check("e5_hit", h, 1);
      end
      send(48'h200, BCAST, 2'd0, 0, m, h, ev);
      check("evict_seen", ev, 1);
      check("evict_mask", m, 4'b1110);
      check("full_after_evict", table_full, 1);
      send(GRP, 48'h10F, 2'd0, 0, m, h, ev);
      check("evicted_miss_mask", m, 4'b1110);
      check("evicted_miss_hit", h, 0);
      send(GRP, 48'h10E, 2'd1, 0, m, h, ev);
      check("e14_mask", m, 4'b0100);
      check("e14_hit", h, 1);
      send(GRP, 48'h200, 2'd1, 0, m, h, ev);
      check("new15_mask", m, 4'b0001);
      check("new15_hit", h, 1);

      // Saturation: 3 + 20 increments must clamp at 15, so it survives 15 ageing passes
      for (int i = 0; i < 20; i++) begin
         send(GRP, 48'h105, 2'd0, 0, m, h, ev);
         check("sat_hit", h, 1);
      end
      for (int i = 0; i < 15; i++) tick(1);
      check("full_after_age", table_full, 0);
      send(GRP, 48'h105, 2'd0, 0, m, h, ev);
      check("sat_survive_hit", h, 1);
      check("sat_survive_mask", m, 4'b0010);
      send(GRP, 48'h10E, 2'd1, 0, m, h, ev);
      check("aged_out_hit", h, 0);
      check("aged_out_mask", m, 4'b1101);

      // Ageing: A (hit 0) dies, B (hit 2) survives
      do_reset();
      send(48'hA, BCAST, 2'd0, 0, m, h, ev);
      send(48'hB, BCAST, 2'd1, 0, m, h, ev);
      send(GRP, 48'hB, 2'd2, 0, m, h, ev);
      send(GRP, 48'hB, 2'd2, 0, m, h, ev);
      tick(1);
      send(GRP, 48'hA, 2'd2, 0, m, h, ev);
      check("age_a_hit", h, 0);
      check("age_a_mask", m, 4'b1011);
      send(GRP, 48'hB, 2'd2, 0, m, h, ev);
      check("age_b_hit", h, 1);
      check("age_b_mask", m, 4'b0010);

      // Tick during LOOKUP (B hit 2 -> 3 -> aged to 2)
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      bus.resp_ready   = 1'b1;
      bus.req_valid    = 1'b1;
      bus.req_src_mac  = GRP;
      bus.req_dst_mac  = 48'hB;
      bus.req_src_port = 2'd2;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      age_tick = 1'b1;
      @(negedge clk);
      age_tick = 1'b0;
      check("busy_resp_valid", bus.resp_valid, 1);
      check("busy_mask", bus.resp_port_mask, 4'b0010);
      check("busy_hit", bus.resp_hit, 1);
      @(negedge clk);
      check("age_blocks_ready", bus.req_ready, 0);
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("age_release_cycles", n, 2);

      // Two back-to-back ticks give one decrement: 2 -> 1, then one more tick -> 0, still valid
      tick(2);
      tick(1);
      send(GRP, 48'hB, 2'd2, 0, m, h, ev);
      check("double_tick_hit", h, 1);
      check("double_tick_mask", m, 4'b0010);

      // Reset while a response is pending
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      bus.resp_ready   = 1'b0;
      bus.req_valid    = 1'b1;
      bus.req_src_mac  = 48'h77;
      bus.req_dst_mac  = 48'hB;
      bus.req_src_port = 2'd0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      n = 0;
      while (bus.resp_valid !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("pre_rst_resp_valid", bus.resp_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", bus.resp_valid, 0);
      check("async_rst_mask", bus.resp_port_mask, 0);
      check("async_rst_hit", bus.resp_hit, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.resp_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("no_resp_after_rst", bus.resp_valid, 0);
      check("ready_after_abort", bus.req_ready, 1);
      check("full_after_abort", table_full, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
